cnt: RTL and testbench
======================

// Module: cnt
//
// PURPOSE
//   Free-running n-bit binary up-counter with synchronous enable.
//   Used as a generic tick/event counter and timebase building block.
//   Counts modulo 2**n, holds its value when disabled, and flags the
//   wrap-around (terminal count) cycle for cascading.
//
// PARAMETERS
//   n     4    counter width in bits; legal range 1..32
//
// PORTS
//   Clk     in   1   single clock; all state updates on the rising edge
//   resetn  in   1   reset: synchronous, active-low
//   en      in   1   count enable; sampled on the rising edge of Clk
//   q       out  n   current count value, driven straight from a register
//   tc      out  1   terminal count, combinational: 1 when q == 2**n-1 and en == 1
//
// BEHAVIOUR
//   - Priority on each rising edge of Clk: resetn, then en, then hold.
//   - resetn == 0: q <= 0, regardless of en. Reset acts only on a clock edge.
//   - resetn == 1, en == 1: q <= q + 1, modulo 2**n.
//     2**n-1 wraps to 0; no saturation and no error flag.
//   - resetn == 1, en == 0: q holds its value.
//   - Latency: a change in en affects q on the first rising edge where en is sampled.
//     No pipeline stages.
//   - q is undefined from power-up until the first edge with resetn == 0.
//     There is no initial-value assignment.
//   - tc = en & (q == {n{1'b1}}). It is combinational from the registers and en.
//     tc is forced to 0 while resetn == 0.
//   - Mid-count reset: if resetn == 0 and en == 1 at the same edge, q = 0 next cycle.
//     tc is 0 during that cycle.
//   - Release of reset: on the first edge with resetn == 1 and en == 1, q goes 0 -> 1.
//   - No handshake; en may toggle every cycle.
//   - Single always_ff block for q; tc uses continuous assignment.
//   - n == 1 degenerates to a toggle flip-flop with tc = en & q.
//
// STRUCTURE
//   - Flat, single module. No sub-modules.
//   - No shared package: the only constant is the all-ones terminal value.
//     It is derived locally from n.
//   - Width check: elaboration-time assertion that 1 <= n <= 32.
//
// TESTING
//   (n = 4, Clk period 10 ns; each value is checked after the rising edge)
//   1. Reset: resetn=0, en=0 for 1 edge -> q = 0x0, tc = 0.
//   2. Count: resetn=1, en=1 for 6 edges from 0 -> q steps 1,2,3,4,5,6.
//   3. Hold: en=0 for 3 edges at q=6 -> q stays 0x6, tc = 0.
//   4. Wrap: en=1 from q=0xE.
//      - Next edge -> q = 0xF; tc = 1 while q = 0xF and en = 1.
//      - Following edge -> q = 0x0, tc = 0.
//   5. Reset mid-count: q=0x9, en=1, resetn=0 for 1 edge -> q = 0x0.
//      Then resetn=1 -> q = 0x1 on the following edge.
//   6. Enable toggling: en alternates 1,0,1,0 from q=0 -> q = 1,1,2,2.
//   Checks: q never changes without a rising edge of Clk.
//   Checks: reference model q_next = !resetn ? 0 : en ? q+1 : q, compared every cycle.

Source files
------------

// File: rtl/cnt.sv
// cnt: free-running n-bit binary up-counter with synchronous enable.
//
// Counts modulo 2**n while enabled and holds its value otherwise. tc flags
// the wrap-around cycle so that counters can be cascaded.
//
// Parameters:
//   n       counter width in bits, 1..32
// Ports:
//   Clk     clock; all state changes on the rising edge
//   resetn  synchronous active-low reset; clears q on a clock edge
//   en      count enable, sampled on the rising edge of Clk
//   q       current count value, driven straight from the register
//   tc      terminal count: en & (q == all ones), forced low during reset
module cnt #(
  parameter int unsigned n = 4
) (
  input  logic         Clk,
  input  logic         resetn,
  input  logic         en,
  output logic [n-1:0] q,
  output logic         tc
);

  // Reject unsupported widths at elaboration.
  if (n < 1 || n > 32) begin : g_width_check
    $error("cnt: parameter n must be in 1..32");
  end

  localparam logic [n-1:0] TermVal = {n{1'b1}};

  logic [n-1:0] q_d, q_q;

  // Priority: reset, then enable, then hold. Addition wraps naturally.
  always_comb begin
    q_d = q_q;
    if (!resetn) begin
      q_d = '0;
    end else if (en) begin
      q_d = q_q + n'(1);
    end
  end

  always_ff @(posedge Clk) begin
    q_q <= q_d;
  end

  assign q  = q_q;
  // Gating with resetn keeps tc low while a reset is pending, even if the
  // register still holds the terminal value.
  assign tc = resetn & en & (q_q == TermVal);

endmodule

// File: tb/tb_cnt.sv
// tb_cnt: directed self-checking bench for cnt at n = 4, with an n = 1
// instance driven in parallel to cover the toggle flip-flop degenerate case.
module tb_cnt;

  logic       Clk;
  logic       resetn;
  logic       en;
  logic [3:0] q;
  logic       tc;
  logic [0:0] q1;
  logic       tc1;

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0] model_q;
  logic       model1_q;

  cnt #(.n(4)) u_dut (
    .Clk    (Clk),
    .resetn (resetn),
    .en     (en),
    .q      (q),
    .tc     (tc)
  );

  cnt #(.n(1)) u_dut1 (
    .Clk    (Clk),
    .resetn (resetn),
    .en     (en),
    .q      (q1),
    .tc     (tc1)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Drive one cycle: apply inputs, check tc before the edge against the
  // hand-computed value, then check q after the edge (hand value and model)
  // and again at the falling edge to confirm q only moves on a rising edge.
  task automatic cycle(input string name, input logic rst, input logic e,
                       input logic [3:0] exp_q, input logic exp_tc);
    logic exp_tc1;
    resetn = rst;
    en     = e;
    #1;
    check_val({name, " tc"}, {31'b0, tc}, {31'b0, exp_tc});
    exp_tc1 = rst & e & model1_q;
    if (rst) check_val({name, " tc1"}, {31'b0, tc1}, {31'b0, exp_tc1});
    else     check_val({name, " tc1_rst"}, {31'b0, tc1}, 32'd0);
    @(posedge Clk);
    if (!rst) begin
      model_q  = 4'h0;
      model1_q = 1'b0;
    end else if (e) begin
      model_q  = model_q + 4'h1;
      model1_q = ~model1_q;
    end
    #1;
    check_val({name, " q"}, {28'b0, q}, {28'b0, exp_q});
    check_val({name, " q_model"}, {28'b0, q}, {28'b0, model_q});
    check_val({name, " q1_model"}, {31'b0, q1}, {31'b0, model1_q});
    @(negedge Clk);
    check_val({name, " q_stable"}, {28'b0, q}, {28'b0, model_q});
  endtask

  initial begin
    resetn   = 1'b0;
    en       = 1'b0;
    model_q  = 4'h0;
    model1_q = 1'b0;

    // Reset with en low.
    cycle("reset", 1'b0, 1'b0, 4'h0, 1'b0);

    // Count 1..6.
    for (int i = 1; i <= 6; i++) cycle("count", 1'b1, 1'b1, 4'(i), 1'b0);

    // Hold at 6.
    for (int i = 0; i < 3; i++) cycle("hold", 1'b1, 1'b0, 4'h6, 1'b0);

    // Count up to 0xE, then 0xF.
    for (int i = 7; i <= 14; i++) cycle("count_hi", 1'b1, 1'b1, 4'(i), 1'b0);
    cycle("to_f", 1'b1, 1'b1, 4'hF, 1'b0);

    // At 0xF with en low tc stays low; with en high tc rises and q wraps.
    cycle("hold_f", 1'b1, 1'b0, 4'hF, 1'b0);
    cycle("wrap", 1'b1, 1'b1, 4'h0, 1'b1);

    // Count to 9, reset with en high, then release.
    for (int i = 1; i <= 9; i++) cycle("count_9", 1'b1, 1'b1, 4'(i), 1'b0);
    cycle("mid_reset", 1'b0, 1'b1, 4'h0, 1'b0);
    cycle("release", 1'b1, 1'b1, 4'h1, 1'b0);

    // Reset while sitting at 0xF with en high: tc must be held low.
    for (int i = 2; i <= 15; i++) cycle("count_f", 1'b1, 1'b1, 4'(i), 1'b0);
    cycle("reset_at_f", 1'b0, 1'b1, 4'h0, 1'b0);

    // Enable toggling from 0.
    cycle("toggle0", 1'b1, 1'b1, 4'h1, 1'b0);
    cycle("toggle1", 1'b1, 1'b0, 4'h1, 1'b0);
    cycle("toggle2", 1'b1, 1'b1, 4'h2, 1'b0);
    cycle("toggle3", 1'b1, 1'b0, 4'h2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
